// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store front end sitting directly in front of
// the word-wide ram. It handles one CPU access at a time and drives the ram
// Cs/We/Addr/Wdata handshake. Load data is extracted from its lane and extended.
// Sub-word stores use read-modify-write with a one-cycle Cs-low gap between the two
// ram accesses. Misaligned and illegal accesses complete with Err and never reach the ram.
// Optional feature: define LSU_TIMEOUT_EN to add an Ack watchdog. With the watchdog, an RD or WR
// that waits TIMEOUT_CYCLES without Ram_ack completes as an error. TIMEOUT_CYCLES exists only
// in that build.

`ifndef RAM_CAPACITY
`define RAM_CAPACITY 1024
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif

module load_store_unit #(
    parameter int ADDR_W = $clog2(`RAM_CAPACITY),
    parameter int DATA_W = 8 * `WORD_SIZE
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    input  logic              Wr,
    input  logic [1:0]        Size,
    input  logic              Sign,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Wdata,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] Rdata,
    output logic [ADDR_W-1:0] Ram_addr,
    output logic              Ram_cs,
    output logic              Ram_we,
    output logic [DATA_W-1:0] Ram_wdata,
    input  logic [DATA_W-1:0] Ram_rdata,
    input  logic              Ram_ack
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t state;
    state_t next_state;

    logic              wr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;

    logic              accept;
    logic              bad_access;
    logic              word_store;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] merged_word;

    assign accept     = Req && (state == ST_IDLE);
    assign word_store = Wr && (Size == 2'b10);

    // Alignment/legality of the incoming request: half needs an even address, word a multiple of four
    always_comb begin
        bad_access = 1'b0;
        case (Size)
            2'b00:   bad_access = 1'b0;
            2'b01:   bad_access = Addr[0];
            2'b10:   bad_access = (Addr[1:0] != 2'b00);
            default: bad_access = 1'b1;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer;
    logic             timed_out;

    assign timed_out = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // Ack watchdog: counts cycles spent waiting in RD/WR, restarts on every state change
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            timer <= '0;
        end else if (next_state != state) begin
            timer <= '0;
        end else if ((state == ST_RD) || (state == ST_WR)) begin
            timer <= timer + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; Ram_ack only matters in RD and WR
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (Req) begin
                    if (bad_access) begin
                        next_state = ST_ERR;
                    end else if (word_store) begin
                        next_state = ST_WR;
                    end else begin
                        next_state = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (Ram_ack) begin
                    next_state = wr_q ? ST_GAP : ST_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (timed_out) begin
                    next_state = ST_ERR;
                end
`endif
            end
            ST_GAP: begin
                next_state = ST_WR;
            end
            ST_WR: begin
                if (Ram_ack) begin
                    next_state = ST_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (timed_out) begin
                    next_state = ST_ERR;
                end
`endif
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            ST_ERR: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign Busy = (state != ST_IDLE);
    assign Done = (state == ST_DONE) || (state == ST_ERR);
    assign Err  = (state == ST_ERR);

    // Capture the request fields at acceptance so the CPU may change its inputs afterwards
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= Wr;
            size_q  <= Size;
            sign_q  <= Sign;
            lane_q  <= Addr[1:0];
            wdata_q <= Wdata;
        end
    end

    // Pick the addressed lane(s) out of the ram word and extend to full width
    always_comb begin
        lane_byte  = Ram_rdata[{lane_q, 3'b000} +: 8];
        lane_half  = Ram_rdata[{lane_q[1], 4'b0000} +: 16];
        load_value = Ram_rdata;
        case (size_q)
            2'b00:   load_value = {{(DATA_W - 8){sign_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_value = {{(DATA_W - 16){sign_q & lane_half[15]}}, lane_half};
            default: load_value = Ram_rdata;
        endcase
    end

    // Overlay the new store lane(s) onto the word read back from ram
    always_comb begin
        merged_word = word_q;
        case (size_q)
            2'b00:   merged_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged_word = wdata_q;
        endcase
    end

    // Registered ram interface and data path; Cs/We follow the state being entered so they
    // are stable throughout RD/WR and drop the cycle after Ack
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Ram_cs    <= 1'b0;
            Ram_we    <= 1'b0;
            Ram_addr  <= '0;
            Ram_wdata <= '0;
            Rdata     <= '0;
            word_q    <= '0;
        end else begin
            Ram_cs <= (next_state == ST_RD) || (next_state == ST_WR);
            Ram_we <= (next_state == ST_WR);
            if (accept && !bad_access) begin
                Ram_addr <= {Addr[ADDR_W-1:2], 2'b00};
                if (word_store) begin
                    Ram_wdata <= Wdata;
                end
            end
            if ((state == ST_RD) && Ram_ack) begin
                if (wr_q) begin
                    word_q <= Ram_rdata;
                end else begin
                    Rdata <= load_value;
                end
            end
            if (state == ST_GAP) begin
                Ram_wdata <= merged_word;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a behavioural word ram
// that acknowledges each chip-select one cycle after it rises, unless stalled.

module tb_load_store_unit;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Req = 1'b0;
    logic              Wr = 1'b0;
    logic [1:0]        Size = 2'b00;
    logic              Sign = 1'b0;
    logic [ADDR_W-1:0] Addr = '0;
    logic [DATA_W-1:0] Wdata = '0;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [DATA_W-1:0] Rdata;
    logic [ADDR_W-1:0] Ram_addr;
    logic              Ram_cs;
    logic              Ram_we;
    logic [DATA_W-1:0] Ram_wdata;
    logic [DATA_W-1:0] Ram_rdata = '0;
    logic              Ram_ack = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    // ram model state
    logic [31:0] mem [0:255];
    logic        ramStall = 1'b0;
    int          cyc = 0;
    int          readCount = 0;
    int          writeCount = 0;
    int          readCyc = 0;
    int          writeCyc = 0;
    int          csHighCount = 0;
    logic [31:0] lastReadData = '0;
    logic [31:0] lastWdata = '0;
    logic        lastAckWasRead = 1'b0;
    logic        afterReadCs = 1'b1;

    load_store_unit #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .Wr        (Wr),
        .Size      (Size),
        .Sign      (Sign),
        .Addr      (Addr),
        .Wdata     (Wdata),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Rdata     (Rdata),
        .Ram_addr  (Ram_addr),
        .Ram_cs    (Ram_cs),
        .Ram_we    (Ram_we),
        .Ram_wdata (Ram_wdata),
        .Ram_rdata (Ram_rdata),
        .Ram_ack   (Ram_ack)
    );

    always #5 Clk = ~Clk;

    // Behavioural ram: one-cycle Ack per chip-select, logs every access it serves
    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (Ram_cs) csHighCount = csHighCount + 1;
        if (lastAckWasRead) afterReadCs = Ram_cs;
        lastAckWasRead = 1'b0;
        if (!Rst) begin
            Ram_ack = 1'b0;
        end else if (Ram_cs && !Ram_ack && !ramStall) begin
            Ram_ack   = 1'b1;
            Ram_rdata = mem[Ram_addr[ADDR_W-1:2]];
            if (Ram_we) begin
                mem[Ram_addr[ADDR_W-1:2]] = Ram_wdata;
                writeCount = writeCount + 1;
                writeCyc   = cyc;
                lastWdata  = Ram_wdata;
            end else begin
                readCount      = readCount + 1;
                readCyc        = cyc;
                lastReadData   = Ram_rdata;
                lastAckWasRead = 1'b1;
            end
        end else begin
            Ram_ack = 1'b0;
        end
    end

    // Sample point: just after the falling edge, well away from the active edge
    task automatic tick;
        @(negedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected)
        else begin
            errorCount = errorCount + 1;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete access: returns cycles from acceptance to Done, Err, and whether
    // Done/Busy are still high one cycle after completion
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sign,
                                 input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic err, output logic after);
        tick;
        Req   = 1'b1;
        Wr    = wr;
        Size  = size;
        Sign  = sign;
        Addr  = addr;
        Wdata = wdata;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        lat = -1;
        err = 1'bx;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (Done) begin
                lat = k;
                err = Err;
                break;
            end
        end
        tick;
        after = Done | Busy;
    endtask

    int          lat;
    int          lat2;
    int          r0;
    int          w0;
    int          cs0;
    int          wrCycSave;
    int          stuckCount;
    logic        err;
    logic        after;
    logic        doneSeen;
    logic        csAtDone;

    initial begin
        // reset
        Rst = 1'b1;
        #2;
        Rst = 1'b0;
        tick;
        tick;
        checkOutput("reset busy", 32'(Busy), 32'h0);
        checkOutput("reset done", 32'(Done), 32'h0);
        checkOutput("reset err", 32'(Err), 32'h0);
        checkOutput("reset rdata", Rdata, 32'h0);
        checkOutput("reset ram_cs", 32'(Ram_cs), 32'h0);
        checkOutput("reset ram_we", 32'(Ram_we), 32'h0);
        checkOutput("reset ram_addr", 32'(Ram_addr), 32'h0);
        checkOutput("reset ram_wdata", Ram_wdata, 32'h0);
        Rst = 1'b1;

        // 1: word store then word load
        r0 = readCount;
        w0 = writeCount;
        applyStimulus(1'b1, 2'b10, 1'b0, 10'h008, 32'haabbccdd, lat, err, after);
        checkOutput("t1 store lat", lat, 32'd1);
        checkOutput("t1 store err", 32'(err), 32'h0);
        checkOutput("t1 store after", 32'(after), 32'h0);
        checkOutput("t1 store writes", writeCount - w0, 32'd1);
        checkOutput("t1 store reads", readCount - r0, 32'd0);
        checkOutput("t1 store wdata", lastWdata, 32'haabbccdd);
        applyStimulus(1'b0, 2'b10, 1'b0, 10'h008, 32'h0, lat, err, after);
        checkOutput("t1 load lat", lat, 32'd1);
        checkOutput("t1 load err", 32'(err), 32'h0);
        checkOutput("t1 load rdata", Rdata, 32'haabbccdd);
        checkOutput("t1 total writes", writeCount - w0, 32'd1);

        // 2: byte store read-modify-write with a Cs-low gap
        applyStimulus(1'b1, 2'b10, 1'b0, 10'h004, 32'h11223344, lat, err, after);
        r0 = readCount;
        w0 = writeCount;
        applyStimulus(1'b1, 2'b00, 1'b0, 10'h006, 32'h123456ee, lat, err, after);
        checkOutput("t2 sb lat", lat, 32'd3);
        checkOutput("t2 sb err", 32'(err), 32'h0);
        checkOutput("t2 sb reads", readCount - r0, 32'd1);
        checkOutput("t2 sb writes", writeCount - w0, 32'd1);
        checkOutput("t2 sb read data", lastReadData, 32'h11223344);
        checkOutput("t2 sb gap cs", 32'(afterReadCs), 32'h0);
        checkOutput("t2 sb gap len", writeCyc - readCyc, 32'd2);
        checkOutput("t2 sb merged", lastWdata, 32'h11ee3344);
        applyStimulus(1'b1, 2'b01, 1'b0, 10'h004, 32'hffffbeef, lat, err, after);
        checkOutput("t2 sh merged", lastWdata, 32'h11eebeef);
        applyStimulus(1'b0, 2'b10, 1'b0, 10'h004, 32'h0, lat, err, after);
        checkOutput("t2 reload", Rdata, 32'h11eebeef);

        // 3: sub-word loads with sign/zero extension
        applyStimulus(1'b1, 2'b10, 1'b0, 10'h000, 32'h80ff7f01, lat, err, after);
        applyStimulus(1'b0, 2'b00, 1'b1, 10'h002, 32'h0, lat, err, after);
        checkOutput("t3 lb signed @2", Rdata, 32'hffffffff);
        applyStimulus(1'b0, 2'b00, 1'b0, 10'h001, 32'h0, lat, err, after);
        checkOutput("t3 lbu @1", Rdata, 32'h0000007f);
        applyStimulus(1'b0, 2'b01, 1'b1, 10'h002, 32'h0, lat, err, after);
        checkOutput("t3 lh signed @2", Rdata, 32'hffff80ff);
        applyStimulus(1'b0, 2'b00, 1'b1, 10'h003, 32'h0, lat, err, after);
        checkOutput("t3 lb signed @3", Rdata, 32'hffffff80);
        applyStimulus(1'b0, 2'b01, 1'b1, 10'h000, 32'h0, lat, err, after);
        checkOutput("t3 lh signed @0", Rdata, 32'h00007f01);
        checkOutput("t3 lh lat", lat, 32'd1);

        // 4: misaligned and illegal accesses never reach ram
        r0  = readCount;
        w0  = writeCount;
        cs0 = csHighCount;
        applyStimulus(1'b0, 2'b01, 1'b1, 10'h003, 32'h0, lat, err, after);
        checkOutput("t4 lh @3 lat", lat, 32'd0);
        checkOutput("t4 lh @3 err", 32'(err), 32'h1);
        checkOutput("t4 lh @3 after", 32'(after), 32'h0);
        checkOutput("t4 lh @3 rdata", Rdata, 32'h00007f01);
        applyStimulus(1'b1, 2'b10, 1'b0, 10'h002, 32'hdeadbeef, lat, err, after);
        checkOutput("t4 sw @2 lat", lat, 32'd0);
        checkOutput("t4 sw @2 err", 32'(err), 32'h1);
        applyStimulus(1'b0, 2'b11, 1'b0, 10'h000, 32'h0, lat, err, after);
        checkOutput("t4 size11 lat", lat, 32'd0);
        checkOutput("t4 size11 err", 32'(err), 32'h1);
        checkOutput("t4 size11 rdata", Rdata, 32'h00007f01);
        checkOutput("t4 cs cycles", csHighCount - cs0, 32'd0);
        checkOutput("t4 ram accesses", (readCount - r0) + (writeCount - w0), 32'd0);

        // 5a: request held across a sub-word store starts only after Done
        r0 = readCount;
        w0 = writeCount;
        tick;
        Req   = 1'b1;
        Wr    = 1'b1;
        Size  = 2'b01;
        Sign  = 1'b0;
        Addr  = 10'h00a;
        Wdata = 32'h0000cafe;
        @(posedge Clk);
        #1;
        Wr    = 1'b0;
        Size  = 2'b10;
        Addr  = 10'h008;
        Wdata = 32'h0;
        lat   = -1;
        err   = 1'bx;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (Done) begin
                lat = k;
                err = Err;
                break;
            end
        end
        checkOutput("t5 held store lat", lat, 32'd3);
        checkOutput("t5 held store err", 32'(err), 32'h0);
        checkOutput("t5 held reads", readCount - r0, 32'd1);
        checkOutput("t5 held merged", lastWdata, 32'hcafeccdd);
        wrCycSave = writeCyc;
        tick;
        checkOutput("t5 idle between", 32'(Busy), 32'h0);
        @(posedge Clk);
        #1;
        Req  = 1'b0;
        lat2 = -1;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (Done) begin
                lat2 = k;
                break;
            end
        end
        checkOutput("t5 second lat", lat2, 32'd1);
        checkOutput("t5 second rdata", Rdata, 32'hcafeccdd);
        checkOutput("t5 second after write", 32'(readCyc > wrCycSave), 32'h1);
        checkOutput("t5 total reads", readCount - r0, 32'd2);

        // 5b: reset dropped mid-WR aborts at once
        w0       = writeCount;
        ramStall = 1'b1;
        tick;
        Req   = 1'b1;
        Wr    = 1'b1;
        Size  = 2'b10;
        Addr  = 10'h010;
        Wdata = 32'h5a5aa5a5;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        tick;
        tick;
        checkOutput("t5 wr cs", 32'(Ram_cs), 32'h1);
        checkOutput("t5 wr we", 32'(Ram_we), 32'h1);
        checkOutput("t5 wr addr", 32'(Ram_addr), 32'h010);
        checkOutput("t5 wr wdata", Ram_wdata, 32'h5a5aa5a5);
        #1;
        Rst = 1'b0;
        #1;
        checkOutput("t5 rst busy", 32'(Busy), 32'h0);
        checkOutput("t5 rst done", 32'(Done), 32'h0);
        checkOutput("t5 rst cs", 32'(Ram_cs), 32'h0);
        checkOutput("t5 rst we", 32'(Ram_we), 32'h0);
        checkOutput("t5 rst addr", 32'(Ram_addr), 32'h0);
        checkOutput("t5 rst wdata", Ram_wdata, 32'h0);
        checkOutput("t5 rst rdata", Rdata, 32'h0);
        doneSeen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            if (Done) doneSeen = 1'b1;
        end
        ramStall = 1'b0;
        Rst      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            if (Done) doneSeen = 1'b1;
        end
        checkOutput("t5 no done", 32'(doneSeen), 32'h0);
        checkOutput("t5 no write", writeCount - w0, 32'd0);

        // 6: ram never acknowledges
        ramStall = 1'b1;
        tick;
        Req  = 1'b1;
        Wr   = 1'b0;
        Size = 2'b10;
        Sign = 1'b0;
        Addr = 10'h000;
        @(posedge Clk);
        #1;
        Req = 1'b0;
`ifdef LSU_TIMEOUT_EN
        lat      = -1;
        err      = 1'bx;
        csAtDone = 1'bx;
        for (int k = 0; k < 60; k++) begin
            tick;
            if (Done) begin
                lat      = k;
                err      = Err;
                csAtDone = Ram_cs;
                break;
            end
        end
        checkOutput("t6 timeout lat", lat, 32'd16);
        checkOutput("t6 timeout err", 32'(err), 32'h1);
        checkOutput("t6 timeout cs", 32'(csAtDone), 32'h0);
        checkOutput("t6 timeout rdata", Rdata, 32'h0);
        tick;
        checkOutput("t6 idle after", 32'(Busy), 32'h0);
        ramStall = 1'b0;
`else
        stuckCount = 0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (Busy && !Done) stuckCount = stuckCount + 1;
        end
        checkOutput("t6 stays busy", stuckCount, 32'd40);
        checkOutput("t6 cs held", 32'(Ram_cs), 32'h1);
        Rst = 1'b0;
        tick;
        ramStall = 1'b0;
        Rst      = 1'b1;
        tick;
        checkOutput("t6 recovered", 32'(Busy), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
